// File: rtl/pic_isr_rotating_unit_pkg.sv
// Shared constants, level typedef and bit-vector helpers for the PIC ISR/rotation logic.
// Helpers work on 32-bit containers so any NUM_IRQ up to 32 can reuse them.
package pic_pkg;

   localparam int PIC_NUM_IRQ_DEFAULT = 8;
   localparam int PIC_MAX_IRQ         = 32;

   typedef logic [4:0] level_t;

   // Bit 'amt' of v lands on bit 0; only the low 'width' bits take part.
   function automatic logic [31:0] rotate_right(input logic [31:0] v, input int width, input int amt);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < PIC_MAX_IRQ; i++) begin
         if (i < width) r[i] = v[5'((i + amt) % width)];
      end
      return r;
   endfunction

   function automatic logic [31:0] rotate_left(input logic [31:0] v, input int width, input int amt);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < PIC_MAX_IRQ; i++) begin
         if (i < width) r[i] = v[5'((i - amt + width) % width)];
      end
      return r;
   endfunction

   function automatic int onehot_to_index(input logic [31:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < PIC_MAX_IRQ; i++) begin
         if (v[i]) idx = idx | i;
      end
      return idx;
   endfunction

   function automatic logic [31:0] lowest_set_onehot(input logic [31:0] v);
      return v & (~v + 32'd1);
   endfunction

   function automatic logic level_ok(input int lvl, input int n);
      return lvl < n;
   endfunction

endpackage

// File: rtl/pic_isr_rotating_unit_if.sv
// Command/status bundle between the INTA control logic and the ISR rotation unit.
interface pic_isr_rotating_unit_if #(
   parameter  int NUM_IRQ = pic_pkg::PIC_NUM_IRQ_DEFAULT,
   localparam int LVL_W   = $clog2(NUM_IRQ)
);
   logic               ack_valid;
   logic [NUM_IRQ-1:0] ack_vector;
   logic               aeoi_en;
   logic               eoi_valid;
   logic               eoi_specific;
   logic               eoi_rotate;
   logic [LVL_W-1:0]   eoi_level;
   logic               aeoi_rotate_en;
   logic               set_prio_valid;
   logic [LVL_W-1:0]   set_prio_level;
   logic [NUM_IRQ-1:0] isr;
   logic [NUM_IRQ-1:0] highest_in_service;
   logic [LVL_W-1:0]   highest_level;
   logic               isr_any;
   logic [LVL_W-1:0]   lowest_prio;

   modport master (
      output ack_valid, ack_vector, aeoi_en, eoi_valid, eoi_specific, eoi_rotate,
             eoi_level, aeoi_rotate_en, set_prio_valid, set_prio_level,
      input  isr, highest_in_service, highest_level, isr_any, lowest_prio
   );

   modport slave (
      input  ack_valid, ack_vector, aeoi_en, eoi_valid, eoi_specific, eoi_rotate,
             eoi_level, aeoi_rotate_en, set_prio_valid, set_prio_level,
      output isr, highest_in_service, highest_level, isr_any, lowest_prio
   );
endinterface

// File: rtl/pic_isr_rotating_unit_prio_enc.sv
// Rotating priority encoder: picks the first set request after lowest_prio, wrapping around.
module pic_rotating_priority_encoder
   import pic_pkg::*;
#(
   parameter  int NUM_IRQ = PIC_NUM_IRQ_DEFAULT,
   localparam int LVL_W   = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   input  logic [LVL_W-1:0]   lowest_prio,
   output logic [NUM_IRQ-1:0] grant,
   output logic [LVL_W-1:0]   grant_level,
   output logic               grant_valid
);
   logic [31:0] req_ext;
   logic [31:0] req_rot;
   logic [31:0] pick_rot;
   logic [31:0] pick;
   int          start;

   // Rotate so the highest-priority level sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      start                = (int'(lowest_prio) + 1) % NUM_IRQ;
      req_ext              = '0;
      req_ext[NUM_IRQ-1:0] = req;
      req_rot              = rotate_right(req_ext, NUM_IRQ, start);
      pick_rot             = lowest_set_onehot(req_rot);
      pick                 = rotate_left(pick_rot, NUM_IRQ, start);
      grant                = pick[NUM_IRQ-1:0];
      grant_level          = LVL_W'(onehot_to_index(pick));
      grant_valid          = |req;
   end
endmodule

// File: rtl/pic_isr_rotating_unit.sv
// Clocked in-service register with EOI/AEOI handling and priority rotation.
// Status outputs are registered from next-state values, so they always agree with isr.
module pic_isr_rotating_unit
   import pic_pkg::*;
#(
   parameter  int NUM_IRQ = PIC_NUM_IRQ_DEFAULT,
   localparam int LVL_W   = $clog2(NUM_IRQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pic_isr_rotating_unit_if.slave bus
);
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [NUM_IRQ-1:0] his_q, his_d;
   logic [LVL_W-1:0]   hlvl_q, hlvl_d;
   logic               any_q, any_d;
   logic [LVL_W-1:0]   lowest_prio_q, lowest_prio_d;

   logic [NUM_IRQ-1:0] ack_grant;
   logic [LVL_W-1:0]   ack_lvl;
   logic               ack_hit;
   logic [NUM_IRQ-1:0] spec_mask;
   logic [NUM_IRQ-1:0] clr_mask;
   logic [NUM_IRQ-1:0] set_mask;
   logic [LVL_W-1:0]   clr_lvl;
   logic               eoi_ok;
   logic               sp_ok;

   // A multi-bit acknowledge collapses to its highest-priority bit under the current rotation.
   pic_rotating_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_ack_sel (
      .req         (bus.ack_vector),
      .lowest_prio (lowest_prio_q),
      .grant       (ack_grant),
      .grant_level (ack_lvl),
      .grant_valid (ack_hit)
   );

   always_comb begin
      eoi_ok    = level_ok(int'(bus.eoi_level), NUM_IRQ);
      sp_ok     = level_ok(int'(bus.set_prio_level), NUM_IRQ);
      spec_mask = {{(NUM_IRQ-1){1'b0}}, 1'b1} << bus.eoi_level;
      clr_mask  = '0;
      clr_lvl   = hlvl_q;
      if (bus.eoi_valid) begin
         if (bus.eoi_specific) begin
            clr_lvl = bus.eoi_level;
            if (eoi_ok) clr_mask = spec_mask;
         end else begin
            clr_mask = his_q;
         end
      end
      set_mask = (bus.ack_valid && !bus.aeoi_en) ? ack_grant : '0;
      isr_d    = (isr_q & ~clr_mask) | set_mask;

      // An out-of-range set-priority is treated as absent, so lower-ranked rotations still apply.
      lowest_prio_d = lowest_prio_q;
      if (bus.set_prio_valid && sp_ok) begin
         lowest_prio_d = bus.set_prio_level;
      end else if (bus.eoi_valid && bus.eoi_rotate && (|clr_mask)) begin
         lowest_prio_d = clr_lvl;
      end else if (bus.ack_valid && bus.aeoi_en && bus.aeoi_rotate_en && ack_hit) begin
         lowest_prio_d = ack_lvl;
      end
   end

   pic_rotating_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_his_sel (
      .req         (isr_d),
      .lowest_prio (lowest_prio_d),
      .grant       (his_d),
      .grant_level (hlvl_d),
      .grant_valid (any_d)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         isr_q         <= '0;
         his_q         <= '0;
         hlvl_q        <= '0;
         any_q         <= 1'b0;
         lowest_prio_q <= LVL_W'(NUM_IRQ - 1);
      end else begin
         isr_q         <= isr_d;
         his_q         <= his_d;
         hlvl_q        <= hlvl_d;
         any_q         <= any_d;
         lowest_prio_q <= lowest_prio_d;
      end
   end

   assign bus.isr                = isr_q;
   assign bus.highest_in_service = his_q;
   assign bus.highest_level      = hlvl_q;
   assign bus.isr_any            = any_q;
   assign bus.lowest_prio        = lowest_prio_q;
endmodule

// File: tb/tb_pic_isr_rotating_unit.sv
// Scenario bench for pic_isr_rotating_unit at NUM_IRQ = 8, 12 and 16.
// Expected post-edge state is queued with each stimulus and checked one cycle later.
module tb_pic_isr_rotating_unit;

   typedef struct {
      bit rst; bit av; int ack; bit ae; bit ar;
      bit ev; bit es; bit er; int el; bit sv; int sl;
   } stim_t;

   typedef struct packed {
      logic [31:0] isr;
      logic [31:0] his;
      logic [31:0] hl;
      logic        any;
      logic [31:0] lp;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pic_isr_rotating_unit_if #(.NUM_IRQ(8))  if8();
   pic_isr_rotating_unit_if #(.NUM_IRQ(12)) if12();
   pic_isr_rotating_unit_if #(.NUM_IRQ(16)) if16();

   pic_isr_rotating_unit #(.NUM_IRQ(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));
   pic_isr_rotating_unit #(.NUM_IRQ(12)) dut12 (.clk(clk), .reset_n(reset_n), .bus(if12));
   pic_isr_rotating_unit #(.NUM_IRQ(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16));

   function automatic stim_t st(bit rst, bit av, int ack, bit ae, bit ar,
                                bit ev, bit es, bit er, int el, bit sv, int sl);
      stim_t s;
      s.rst = rst; s.av = av; s.ack = ack; s.ae = ae; s.ar = ar;
      s.ev = ev; s.es = es; s.er = er; s.el = el; s.sv = sv; s.sl = sl;
      return s;
   endfunction

   function automatic exp_t ex(int isr, int his, int hl, bit any, int lp);
      exp_t e;
      e.isr = 32'(isr); e.his = 32'(his); e.hl = 32'(hl); e.any = any; e.lp = 32'(lp);
      return e;
   endfunction

   task automatic drive(input int dut, input stim_t s);
      reset_n = !s.rst;
      case (dut)
         8: begin
            if8.ack_valid = s.av; if8.ack_vector = 8'(s.ack); if8.aeoi_en = s.ae;
            if8.aeoi_rotate_en = s.ar; if8.eoi_valid = s.ev; if8.eoi_specific = s.es;
            if8.eoi_rotate = s.er; if8.eoi_level = 3'(s.el);
            if8.set_prio_valid = s.sv; if8.set_prio_level = 3'(s.sl);
         end
         12: begin
            if12.ack_valid = s.av; if12.ack_vector = 12'(s.ack); if12.aeoi_en = s.ae;
            if12.aeoi_rotate_en = s.ar; if12.eoi_valid = s.ev; if12.eoi_specific = s.es;
            if12.eoi_rotate = s.er; if12.eoi_level = 4'(s.el);
            if12.set_prio_valid = s.sv; if12.set_prio_level = 4'(s.sl);
         end
         default: begin
            if16.ack_valid = s.av; if16.ack_vector = 16'(s.ack); if16.aeoi_en = s.ae;
            if16.aeoi_rotate_en = s.ar; if16.eoi_valid = s.ev; if16.eoi_specific = s.es;
            if16.eoi_rotate = s.er; if16.eoi_level = 4'(s.el);
            if16.set_prio_valid = s.sv; if16.set_prio_level = 4'(s.sl);
         end
      endcase
   endtask

   function automatic exp_t sample(input int dut);
      exp_t r;
      case (dut)
         8:  r = ex(int'(if8.isr), int'(if8.highest_in_service), int'(if8.highest_level),
                    if8.isr_any, int'(if8.lowest_prio));
         12: r = ex(int'(if12.isr), int'(if12.highest_in_service), int'(if12.highest_level),
                    if12.isr_any, int'(if12.lowest_prio));
         default: r = ex(int'(if16.isr), int'(if16.highest_in_service), int'(if16.highest_level),
                         if16.isr_any, int'(if16.lowest_prio));
      endcase
      return r;
   endfunction

   function automatic stim_t idle();
      return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic test_reset();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 7));
      for (int i = 0; i < s.size(); i++) begin
         drive(8, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(8, idle());
         got = sample(8); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("reset[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   task automatic test_ack_nesting();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0, 1, 'h08, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h08, 'h08, 3, 1, 7));
      s.push_back(st(0, 1, 'h02, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h0A, 'h02, 1, 1, 7));
      for (int i = 0; i < s.size(); i++) begin
         drive(8, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(8, idle());
         got = sample(8); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL ack_nesting[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("ack_nesting[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   task automatic test_eoi_rotate();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));    e.push_back(ex('h08, 'h08, 3, 1, 1));
      s.push_back(st(0, 1, 'h01, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h09, 'h08, 3, 1, 1));
      s.push_back(st(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));    e.push_back(ex('h01, 'h01, 0, 1, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(8, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(8, idle());
         got = sample(8); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL eoi_rotate[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("eoi_rotate[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   task automatic test_specific_eoi();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0, 1, 'h08, 0, 0, 1, 1, 0, 3, 0, 0)); e.push_back(ex('h09, 'h08, 3, 1, 1));
      s.push_back(st(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));    e.push_back(ex('h08, 'h08, 3, 1, 0));
      s.push_back(st(0, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0));    e.push_back(ex('h08, 'h08, 3, 1, 5));
      s.push_back(st(0, 1, 'h88, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h88, 'h80, 7, 1, 5));
      s.push_back(st(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));    e.push_back(ex('h08, 'h08, 3, 1, 5));
      s.push_back(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));    e.push_back(ex('h08, 'h08, 3, 1, 5));
      s.push_back(st(0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0));    e.push_back(ex(0, 0, 0, 0, 5));
      for (int i = 0; i < s.size(); i++) begin
         drive(8, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(8, idle());
         got = sample(8); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL specific_eoi[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("specific_eoi[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   task automatic test_aeoi_set_prio();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));    e.push_back(ex(0, 0, 0, 0, 7));
      s.push_back(st(0, 1, 'h20, 1, 1, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 5));
      s.push_back(st(0, 1, 'h04, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 5));
      s.push_back(st(0, 1, 'h04, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h04, 'h04, 2, 1, 5));
      s.push_back(st(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 7));    e.push_back(ex(0, 0, 0, 0, 7));
      s.push_back(st(0, 1, 'h06, 1, 1, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));    e.push_back(ex(0, 0, 0, 0, 3));
      for (int i = 0; i < s.size(); i++) begin
         drive(8, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(8, idle());
         got = sample(8); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL aeoi_set_prio[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("aeoi_set_prio[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   task automatic test_out_of_range();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0, 1, 'h800, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h800, 'h800, 11, 1, 11));
      s.push_back(st(0, 0, 0, 0, 0, 1, 1, 1, 13, 0, 0));    e.push_back(ex('h800, 'h800, 11, 1, 11));
      s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14));    e.push_back(ex('h800, 'h800, 11, 1, 11));
      s.push_back(st(0, 1, 'h010, 1, 1, 0, 0, 0, 0, 1, 14)); e.push_back(ex('h800, 'h800, 11, 1, 4));
      s.push_back(st(0, 0, 0, 0, 0, 1, 1, 0, 15, 0, 0));    e.push_back(ex('h800, 'h800, 11, 1, 4));
      s.push_back(st(0, 0, 0, 0, 0, 1, 1, 0, 11, 0, 0));    e.push_back(ex(0, 0, 0, 0, 4));
      for (int i = 0; i < s.size(); i++) begin
         drive(12, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(12, idle());
         got = sample(12); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL out_of_range[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("out_of_range[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   task automatic test_wrap16();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14));     e.push_back(ex(0, 0, 0, 0, 14));
      s.push_back(st(0, 1, 'h8000, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h8000, 'h8000, 15, 1, 14));
      s.push_back(st(0, 1, 'h0001, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h8001, 'h8000, 15, 1, 14));
      s.push_back(st(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));      e.push_back(ex('h0001, 'h0001, 0, 1, 14));
      s.push_back(st(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));      e.push_back(ex(0, 0, 0, 0, 14));
      s.push_back(st(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));      e.push_back(ex(0, 0, 0, 0, 14));
      for (int i = 0; i < s.size(); i++) begin
         drive(16, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(16, idle());
         got = sample(16); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL wrap16[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("wrap16[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   task automatic test_reset_mid();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex('h10, 'h10, 4, 1, 3));
      s.push_back(st(1, 1, 'h01, 0, 0, 1, 0, 1, 0, 1, 2)); e.push_back(ex(0, 0, 0, 0, 7));
      s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));    e.push_back(ex(0, 0, 0, 0, 7));
      for (int i = 0; i < s.size(); i++) begin
         drive(8, s[i]); sb.push_back(e[i]);
         @(posedge clk); #1; drive(8, idle());
         got = sample(8); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got isr=%h his=%h lvl=%0d any=%0b lp=%0d, want isr=%h his=%h lvl=%0d any=%0b lp=%0d",
                     i, got.isr, got.his, got.hl, got.any, got.lp, want.isr, want.his, want.hl, want.any, want.lp);
         end else $display("reset_mid[%0d] isr=%h his=%h lvl=%0d lp=%0d", i, got.isr, got.his, got.hl, got.lp);
      end
   endtask

   initial begin
      drive(8, idle());
      drive(12, idle());
      drive(16, idle());
      reset_n = 1'b0;
      test_reset();
      test_ack_nesting();
      test_eoi_rotate();
      test_specific_eoi();
      test_aeoi_set_prio();
      test_out_of_range();
      test_wrap16();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
